param_dep_resolver: RTL and testbench
=====================================

Name: param_dep_resolver

Overview:
- Hardware dependency resolver for a set of up to N_NODES named values (parameters). Each value may depend on other values.
- Accepts a stream of "node depends on dep" edges, then on start emits a legal evaluation order, one node per handshake.
- Detects and reports any dependency cycle, including self-reference, mutual reference and longer loops.
- Consumer end of the elaboration-dependency interface: the producer declares the dependencies, this block resolves them.

Parameters:
- N_NODES, 8, number of node slots (2..32).
- ID_W, $clog2(N_NODES), node index width (derived; not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  synchronous clear. Empties the dependency matrix and returns to IDLE.
- edge_valid  in  1  edge offered.
- edge_ready  out  1  edge accepted when high together with edge_valid.
- edge_node  in  ID_W  dependent node.
- edge_dep  in  ID_W  node it depends on.
- node_en  in  N_NODES  enabled-node mask, sampled at start.
- start  in  1  begin resolution (pulse).
- busy  out  1  high in SCAN or EMIT.
- out_valid  out  1  resolved node offered.
- out_ready  in  1  downstream accepts resolved node.
- out_node  out  ID_W  next node in evaluation order.
- done  out  1  resolution finished. Level signal, held in DONE.
- cycle_err  out  1  resolution stopped on a cycle. Valid while done is high.
- cycle_node  out  ID_W  lowest-index unresolved enabled node when cycle_err is set.

Behaviour:
- Reset: all outputs 0, matrix cleared, resolved mask 0, state IDLE. edge_ready goes to 1 the first cycle after reset is released.
- clear has the same effect as rst, from any state, including mid-resolution. clear has priority over start and edge handshakes in the same cycle.
- Storage: dep[i] is an N_NODES-bit row. Bit j set means node i depends on node j. An edge handshake sets dep[edge_node][edge_dep]. Duplicate edges are idempotent. Edges cannot be removed except by clear/rst.
- Edge indices >= N_NODES are accepted and dropped; no matrix bit is written.
- edge_ready = (state == IDLE) || (state == DONE). No edges are accepted while busy.
- States:
  - IDLE: on start, latch node_en and set resolved = ~node_en. Disabled nodes count as already resolved and are never emitted. Go to SCAN.
  - SCAN: one cycle. Combinationally pick the lowest-index i with node_en[i], !resolved[i] and (dep[i] & ~resolved) == 0.
    - If found: latch out_node = i, go to EMIT.
    - Else if all enabled nodes are resolved: done=1, cycle_err=0, go to DONE.
    - Else: done=1, cycle_err=1, cycle_node = lowest unresolved enabled index, go to DONE.
  - EMIT: out_valid=1. out_node is held stable until out_ready. On handshake, set resolved[out_node], drop out_valid, go to SCAN.
  - DONE: done and cycle_err/cycle_node are held. On start, clear done/cycle_err/cycle_node and behave as IDLE+start. Edge loading is allowed in DONE.
- start is ignored while busy.
- A self-edge (i depends on i) can never be satisfied. It is therefore reported as a cycle at i, or at a lower-index node that is also blocked.
- Latency:
  - start sampled at edge t gives first out_valid at t+2.
  - Each out handshake gives the next out_valid 2 cycles later.
  - Final handshake gives done 2 cycles later.
- Empty node_en: start leads to done=1, cycle_err=0 at t+2 with no out_valid.
- Nodes emitted before a cycle is found remain valid outputs. Downstream uses cycle_err to discard the partial order if needed.

Decomposition:
- Package param_dep_pkg holds:
  - state enum (IDLE, SCAN, EMIT, DONE);
  - node_id_t typedef and mask_t typedef;
  - function lowest_set(mask_t) returning a valid flag and an index.
- One sub-module, dep_ready_pick: purely combinational. Takes the dep matrix, resolved mask and enable mask. Returns found, pick index, all_done, and the blocked index. The top level holds the FSM and storage.

Test Plan:
- Self loop: edge (0,0), node_en=0x01, start -> no out_valid; done=1, cycle_err=1, cycle_node=0 at start+2.
- Mutual loop: edges (0,1),(1,0), node_en=0x03 -> cycle_err=1, cycle_node=0, zero emissions.
- Chain: edges (2,1),(1,0), node_en=0x07, out_ready=1 -> out_node sequence 0,1,2 at cycles t+2, t+4, t+6; done=1, cycle_err=0 at t+8.
- Partial cycle: nodes 0..3, edges (0,1),(1,2),(1,0),(2,1),(2,3), node_en=0x0F -> emits 3 only, then cycle_err=1, cycle_node=0.
- Backpressure and disabled dep: edge (1,5), node_en=0x03, out_ready low 5 cycles -> out_node=0 held stable; then 1 emitted (node 5 treated as resolved); no error.
- Clear mid-run: assert clear during EMIT -> next cycle out_valid=0, busy=0, edge_ready=1. A re-start with node_en=0x03 emits 0,1 (matrix empty).

Source files
------------

// File: rtl/param_dep_resolver_pkg.sv
// Shared types and helpers for the parameter dependency resolver.
package param_dep_pkg;

  localparam int unsigned N_NODES = 8;
  localparam int unsigned ID_W    = $clog2(N_NODES);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_e;

  typedef logic [ID_W-1:0]    node_id_t;
  typedef logic [N_NODES-1:0] mask_t;
  typedef mask_t [N_NODES-1:0] dep_mat_t;

  typedef struct packed {
    logic     valid;
    node_id_t idx;
  } pick_t;

  // Lowest set bit of a mask; valid is clear when the mask is empty.
  function automatic pick_t lowest_set(input mask_t m);
    pick_t r;
    r = '0;
    for (int i = N_NODES - 1; i >= 0; i--) begin
      if (m[i]) begin
        r.valid = 1'b1;
        r.idx   = ID_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/param_dep_resolver_if.sv
// Edge-load, control and resolved-order signals of the dependency resolver.
interface param_dep_resolver_if;
  import param_dep_pkg::*;

  logic     clear;
  logic     edge_valid;
  logic     edge_ready;
  node_id_t edge_node;
  node_id_t edge_dep;
  mask_t    node_en;
  logic     start;
  logic     busy;
  logic     out_valid;
  logic     out_ready;
  node_id_t out_node;
  logic     done;
  logic     cycle_err;
  node_id_t cycle_node;

  modport master (
    output clear, edge_valid, edge_node, edge_dep, node_en, start, out_ready,
    input  edge_ready, busy, out_valid, out_node, done, cycle_err, cycle_node
  );

  modport slave (
    input  clear, edge_valid, edge_node, edge_dep, node_en, start, out_ready,
    output edge_ready, busy, out_valid, out_node, done, cycle_err, cycle_node
  );
endinterface

// File: rtl/param_dep_resolver_pick.sv
// Combinational selection of the lowest-index node whose dependencies are all resolved.
module dep_ready_pick
  import param_dep_pkg::*;
(
  input  dep_mat_t dep_i,
  input  mask_t    resolved_i,
  input  mask_t    en_i,
  output logic     found_o,
  output node_id_t pick_o,
  output logic     all_done_o,
  output node_id_t blocked_o
);

  mask_t unres_c;
  mask_t ready_c;
  pick_t pick_r;
  pick_t blk_r;

  assign unres_c = en_i & ~resolved_i;

  always_comb begin
    ready_c = '0;
    for (int i = 0; i < N_NODES; i++) begin
      ready_c[i] = unres_c[i] && ((dep_i[i] & ~resolved_i) == '0);
    end
  end

  assign pick_r     = lowest_set(ready_c);
  assign blk_r      = lowest_set(unres_c);
  assign found_o    = pick_r.valid;
  assign pick_o     = pick_r.idx;
  assign all_done_o = (unres_c == '0);
  assign blocked_o  = blk_r.idx;

endmodule

// File: rtl/param_dep_resolver.sv
// Dependency matrix storage and resolution FSM; emits a legal evaluation order or flags a cycle.
module param_dep_resolver
  import param_dep_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  param_dep_resolver_if.slave bus
);

  state_e   state_q, state_d;
  dep_mat_t dep_q, dep_d;
  mask_t    en_q, en_d;
  mask_t    resolved_q, resolved_d;
  logic     edge_ready_q, edge_ready_d;
  logic     busy_q, busy_d;
  logic     out_valid_q, out_valid_d;
  logic     done_q, done_d;
  logic     cycle_err_q, cycle_err_d;
  node_id_t out_node_q, out_node_d;
  node_id_t cycle_node_q, cycle_node_d;

  logic     found_c, all_done_c, start_ok_c, edge_hs_c;
  node_id_t pick_c, blocked_c;

  dep_ready_pick u_pick (
    .dep_i      (dep_q),
    .resolved_i (resolved_q),
    .en_i       (en_q),
    .found_o    (found_c),
    .pick_o     (pick_c),
    .all_done_o (all_done_c),
    .blocked_o  (blocked_c)
  );

  assign start_ok_c = bus.start && (state_q == IDLE || state_q == DONE);
  assign edge_hs_c  = bus.edge_valid && edge_ready_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    state_d = found_c ? EMIT : DONE;
      EMIT:    if (bus.out_ready) state_d = SCAN;
      DONE:    if (bus.start) state_d = SCAN;
      default: state_d = IDLE;
    endcase
    if (bus.clear) state_d = IDLE;
  end

  always_comb begin
    dep_d        = dep_q;
    en_d         = en_q;
    resolved_d   = resolved_q;
    out_node_d   = out_node_q;
    done_d       = done_q;
    cycle_err_d  = cycle_err_q;
    cycle_node_d = cycle_node_q;

    // Indices outside the node range never match a row/column and are dropped.
    if (edge_hs_c) begin
      for (int i = 0; i < N_NODES; i++) begin
        for (int j = 0; j < N_NODES; j++) begin
          if (bus.edge_node == ID_W'(i) && bus.edge_dep == ID_W'(j)) dep_d[i][j] = 1'b1;
        end
      end
    end

    if (start_ok_c) begin
      en_d         = bus.node_en;
      resolved_d   = ~bus.node_en;
      done_d       = 1'b0;
      cycle_err_d  = 1'b0;
      cycle_node_d = '0;
    end

    if (state_q == SCAN) begin
      if (found_c) begin
        out_node_d = pick_c;
      end else if (all_done_c) begin
        done_d = 1'b1;
      end else begin
        done_d       = 1'b1;
        cycle_err_d  = 1'b1;
        cycle_node_d = blocked_c;
      end
    end

    if (state_q == EMIT && bus.out_ready) resolved_d[out_node_q] = 1'b1;

    edge_ready_d = (state_d == IDLE) || (state_d == DONE);
    busy_d       = (state_d == SCAN) || (state_d == EMIT);
    out_valid_d  = (state_d == EMIT);

    if (bus.clear) begin
      dep_d        = '0;
      en_d         = '0;
      resolved_d   = '0;
      out_node_d   = '0;
      done_d       = 1'b0;
      cycle_err_d  = 1'b0;
      cycle_node_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dep_q        <= '0;
      en_q         <= '0;
      resolved_q   <= '0;
      edge_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      cycle_err_q  <= 1'b0;
      out_node_q   <= '0;
      cycle_node_q <= '0;
    end else begin
      dep_q        <= dep_d;
      en_q         <= en_d;
      resolved_q   <= resolved_d;
      edge_ready_q <= edge_ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      cycle_err_q  <= cycle_err_d;
      out_node_q   <= out_node_d;
      cycle_node_q <= cycle_node_d;
    end
  end

  assign bus.edge_ready = edge_ready_q;
  assign bus.busy       = busy_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_node   = out_node_q;
  assign bus.done       = done_q;
  assign bus.cycle_err  = cycle_err_q;
  assign bus.cycle_node = cycle_node_q;

endmodule

// File: tb/tb_param_dep_resolver.sv
// Directed bench for param_dep_resolver: cycles, chains, backpressure, clear and restart.
module tb_param_dep_resolver;
  import param_dep_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  param_dep_resolver_if bus_if ();

  param_dep_resolver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_edge(input int n, input int d);
    check_eq("edge_ready_before_load", 32'(bus_if.edge_ready), 32'd1);
    bus_if.edge_valid = 1'b1;
    bus_if.edge_node  = ID_W'(n);
    bus_if.edge_dep   = ID_W'(d);
    tick();
    bus_if.edge_valid = 1'b0;
  endtask

  // Leaves the bench in the SCAN cycle (t+1).
  task automatic start_run(input mask_t en);
    bus_if.node_en = en;
    bus_if.start   = 1'b1;
    tick();
    bus_if.start   = 1'b0;
    check_eq("scan_busy", 32'(bus_if.busy), 32'd1);
    check_eq("scan_no_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("scan_no_edge_ready", 32'(bus_if.edge_ready), 32'd0);
  endtask

  task automatic do_clear();
    bus_if.clear = 1'b1;
    tick();
    bus_if.clear = 1'b0;
    check_eq("clear_edge_ready", 32'(bus_if.edge_ready), 32'd1);
    check_eq("clear_busy", 32'(bus_if.busy), 32'd0);
    check_eq("clear_out_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("clear_done", 32'(bus_if.done), 32'd0);
  endtask

  // One EMIT cycle with out_ready high, then the following SCAN cycle.
  task automatic emit_seq(input int node);
    tick();
    check_eq("emit_valid", 32'(bus_if.out_valid), 32'd1);
    check_eq("emit_node", 32'(bus_if.out_node), 32'(node));
    tick();
    check_eq("post_emit_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("post_emit_busy", 32'(bus_if.busy), 32'd1);
  endtask

  task automatic expect_done(input logic err, input int node);
    tick();
    check_eq("done", 32'(bus_if.done), 32'd1);
    check_eq("cycle_err", 32'(bus_if.cycle_err), 32'(err));
    check_eq("cycle_node", 32'(bus_if.cycle_node), 32'(node));
    check_eq("done_no_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("done_not_busy", 32'(bus_if.busy), 32'd0);
    check_eq("done_edge_ready", 32'(bus_if.edge_ready), 32'd1);
  endtask

  initial begin
    bus_if.clear      = 1'b0;
    bus_if.edge_valid = 1'b0;
    bus_if.edge_node  = '0;
    bus_if.edge_dep   = '0;
    bus_if.node_en    = '0;
    bus_if.start      = 1'b0;
    bus_if.out_ready  = 1'b1;

    // Reset state
    tick();
    tick();
    check_eq("rst_edge_ready", 32'(bus_if.edge_ready), 32'd0);
    check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
    check_eq("rst_done", 32'(bus_if.done), 32'd0);
    check_eq("rst_cycle_err", 32'(bus_if.cycle_err), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_edge_ready", 32'(bus_if.edge_ready), 32'd1);

    // Self loop, then restart straight from DONE with an independent node
    send_edge(0, 0);
    start_run(8'h01);
    expect_done(1'b1, 0);
    start_run(8'h02);
    check_eq("restart_done_cleared", 32'(bus_if.done), 32'd0);
    check_eq("restart_err_cleared", 32'(bus_if.cycle_err), 32'd0);
    emit_seq(1);
    expect_done(1'b0, 0);

    // Mutual loop
    do_clear();
    send_edge(0, 1);
    send_edge(1, 0);
    start_run(8'h03);
    expect_done(1'b1, 0);

    // Chain 2->1->0 with a duplicate edge
    do_clear();
    send_edge(2, 1);
    send_edge(1, 0);
    send_edge(1, 0);
    start_run(8'h07);
    emit_seq(0);
    emit_seq(1);
    emit_seq(2);
    expect_done(1'b0, 0);

    // Partial cycle: only node 3 can be emitted
    do_clear();
    send_edge(0, 1);
    send_edge(1, 2);
    send_edge(1, 0);
    send_edge(2, 1);
    send_edge(2, 3);
    start_run(8'h0F);
    emit_seq(3);
    expect_done(1'b1, 0);

    // Empty enable mask
    do_clear();
    start_run(8'h00);
    expect_done(1'b0, 0);

    // Backpressure; dependency on disabled node 5 counts as resolved
    do_clear();
    send_edge(1, 5);
    bus_if.out_ready = 1'b0;
    start_run(8'h03);
    tick();
    check_eq("bp_valid", 32'(bus_if.out_valid), 32'd1);
    check_eq("bp_node", 32'(bus_if.out_node), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("bp_hold_valid", 32'(bus_if.out_valid), 32'd1);
      check_eq("bp_hold_node", 32'(bus_if.out_node), 32'd0);
    end
    bus_if.out_ready = 1'b1;
    tick();
    check_eq("bp_release_valid", 32'(bus_if.out_valid), 32'd0);
    emit_seq(1);
    expect_done(1'b0, 0);

    // Clear mid-emit (with a concurrent start) empties the matrix
    do_clear();
    send_edge(0, 1);
    bus_if.out_ready = 1'b0;
    start_run(8'h03);
    tick();
    check_eq("pre_clear_valid", 32'(bus_if.out_valid), 32'd1);
    check_eq("pre_clear_node", 32'(bus_if.out_node), 32'd1);
    bus_if.start = 1'b1;
    do_clear();
    bus_if.start = 1'b0;
    bus_if.out_ready = 1'b1;
    start_run(8'h03);
    emit_seq(0);
    emit_seq(1);
    expect_done(1'b0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
